seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked, sequential ALU: a registered successor to the 4-bit combinational ALU, generalised to WIDTH bits with eight operations, status flags, and a multi-cycle unsigned shift-add multiplier. Operands enter through a valid/ready input port. Results leave through a valid/ready output port and are held until consumed. It sits between the datapath sequencer and the register-file writeback stage.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥4
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept; handshake when in_valid && in_ready at a rising edge
- a  in  WIDTH  operand A (unsigned; two's complement for overflow)
- b  in  WIDTH  operand B; low $clog2(WIDTH) bits are shift amount for shifts
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (unsigned)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result; handshake when out_valid && out_ready at a rising edge
- result  out  WIDTH  result; low half of product for MUL
- result_hi  out  WIDTH  high half of product for MUL; 0 for all other ops
- carry  out  1  carry/borrow/shift-out flag
- overflow  out  1  signed overflow flag
- zero  out  1  result is zero

## Operation
- FSM states: IDLE, MUL, DONE. Reset state is IDLE.
- in_ready = (state == IDLE) && rst_n. Inputs are ignored in every other state.
- IDLE, accept, non-MUL op: result and flags are computed and registered at the accept edge; next state is DONE.
- IDLE, accept, MUL: a, b and op are latched; the accumulator is cleared; cnt = 0; next state is MUL.
- MUL: one shift-add iteration per cycle. The multiplier LSB gates an add of the multiplicand into the 2·WIDTH accumulator. At the iteration where cnt == WIDTH-1, the product and flags are registered and the next state is DONE.
- DONE: out_valid = 1. result, result_hi and the flags are held stable until the out handshake; the next state is then IDLE.
- Flags:
  - ADD: carry = carry-out of bit WIDTH-1.
  - SUB (a−b): carry = borrow, i.e. 1 when a < b unsigned.
  - ADD/SUB: overflow = signed overflow.
  - SHL: carry = last bit shifted out of the MSB. SHR: carry = last bit shifted out of the LSB. For both shifts, carry = 0 when the shift amount is 0.
  - MUL: carry = (result_hi != 0).
  - AND/OR/XOR: carry = 0.
  - overflow = 0 for every op other than ADD/SUB.
  - zero = ({result_hi, result} == 0).
- Arithmetic is modulo 2^WIDTH, except MUL, which carries the full 2·WIDTH-bit product.
- rst_n low at any time forces:
  - state = IDLE;
  - in_ready = 0;
  - out_valid, result, result_hi, carry, overflow, zero = 0;
  - any in-flight operation is discarded.
  - After release, in_ready = 1 in the next cycle.

## Timing
- Non-MUL latency: out_valid is high in the cycle after the accept edge (1 cycle).
- MUL latency: out_valid rises WIDTH+1 cycles after the accept edge (accept edge plus WIDTH iteration edges).
- Earliest re-accept: in the cycle after the out handshake. Peak throughput is one non-MUL op per 2 cycles.
- Backpressure: out_ready low holds DONE indefinitely. Outputs must not change, and in_ready stays 0.
- out_ready high while out_valid is low has no effect. in_valid high outside IDLE has no effect.
- All outputs are registered; there is no combinational path from the inputs to the outputs, except rst_n into in_ready.

## Test plan
- ADD, WIDTH=8, a=0x7F, b=0x01, out_ready=1: result=0x80, carry=0, overflow=1, zero=0. out_valid is high exactly 1 cycle after accept and for 1 cycle only.
- SUB, a=0x03, b=0x05: result=0xFE, carry=1, overflow=0. Then SUB with a=0x80, b=0x01: result=0x7F, overflow=1, carry=0.
- MUL, a=0xFF, b=0xFF: result=0x01, result_hi=0xFE, carry=1, zero=0, out_valid rises 9 cycles after accept. MUL with a=0x00, b=0x37: zero=1, carry=0.
- SHL, a=0x81, b=0x01: result=0x02, carry=1. SHR, a=0x81, b=0x00: result=0x81, carry=0. XOR, a=0x5A, b=0x5A: result=0x00, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an AND result (a=0xF0, b=0x3C, result=0x30). Outputs are stable, in_ready=0, and a pulse on in_valid with new operands is ignored. Releasing out_ready completes the handshake, and in_ready=1 on the next cycle.
- Reset mid-MUL: drive rst_n low 4 cycles after a MUL accept. All outputs go to 0 immediately (asynchronously). After release, a fresh ADD with a=0x01, b=0x01 gives result=0x02 with 1-cycle latency and no stale MUL output.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops and a WIDTH-cycle
// shift-add unsigned multiplier, with results held until the consumer takes them.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t state, next_state;

   logic                 accept;
   logic                 last_iter;
   logic [SW-1:0]        cnt;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_next;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [WIDTH:0]       shl_ext;
   logic [WIDTH:0]       shr_ext;
   logic [SW-1:0]        shamt;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_carry;
   logic                 alu_ovf;

   // rst_n feeds in_ready directly so nothing can be accepted while reset is held
   assign in_ready  = (state == IDLE) && rst_n;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign last_iter = (state == MUL) && (cnt == SW'(WIDTH - 1));
   assign acc_next  = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (op == OP_MUL) ? MUL : DONE;
         MUL:     if (last_iter) next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The extra bit on each shift catches the last bit pushed out of the word
   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      shamt     = b[SW-1:0];
      shl_ext   = {1'b0, a} << shamt;
      shr_ext   = {a, 1'b0} >> shamt;
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SHL: begin
            alu_res   = shl_ext[WIDTH-1:0];
            alu_carry = shl_ext[WIDTH];
         end
         OP_SHR: begin
            alu_res   = shr_ext[WIDTH:1];
            alu_carry = shr_ext[0];
         end
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         result_hi <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
      end else if (accept) begin
         if (op == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
         end else begin
            result    <= alu_res;
            result_hi <= '0;
            carry     <= alu_carry;
            overflow  <= alu_ovf;
            zero      <= (alu_res == '0);
         end
      end else if (state == MUL) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (last_iter) begin
            result    <= acc_next[WIDTH-1:0];
            result_hi <= acc_next[2*WIDTH-1:WIDTH];
            carry     <= |acc_next[2*WIDTH-1:WIDTH];
            overflow  <= 1'b0;
            zero      <= (acc_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases, backpressure, reset mid-multiply,
// and randomized traffic checked against an arithmetic reference model.
module tb_seq_alu;

   localparam int W  = 8;
   localparam int SW = $clog2(W);

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         c;
      logic         v;
      logic         z;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   op;
      res_t         exp;
   } dir_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         carry;
   logic         overflow;
   logic         zero;

   int n_vectors;
   int n_miscompares;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string show(res_t r);
      return $sformatf("res=%h hi=%h c=%b v=%b z=%b", r.res, r.hi, r.c, r.v, r.z);
   endfunction

   function automatic res_t observed();
      return res_t'{result, result_hi, carry, overflow, zero};
   endfunction

   // Reference model straight from the arithmetic definitions of each operation
   function automatic res_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic [2:0] mop);
      res_t   r;
      longint m    = longint'(1) << W;
      longint ua   = longint'(ma);
      longint ub   = longint'(mb);
      longint sa   = ma[W-1] ? ua - m : ua;
      longint sb   = mb[W-1] ? ub - m : ub;
      longint sh   = ub % W;
      longint full = 0;
      longint s    = 0;
      r = '0;
      case (mop)
         3'd0: begin
            full  = ua + ub;
            r.res = W'(full % m);
            r.c   = (full >= m);
            s     = sa + sb;
            r.v   = (s >= m / 2) || (s < -(m / 2));
         end
         3'd1: begin
            full  = ua - ub;
            r.res = W'((full + m) % m);
            r.c   = (ua < ub);
            s     = sa - sb;
            r.v   = (s >= m / 2) || (s < -(m / 2));
         end
         3'd2: r.res = ma & mb;
         3'd3: r.res = ma | mb;
         3'd4: r.res = ma ^ mb;
         3'd5: begin
            r.res = W'((ua << sh) % m);
            r.c   = (sh != 0) && (((ua >> (W - sh)) & 1) == 1);
         end
         3'd6: begin
            r.res = W'(ua >> sh);
            r.c   = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1);
         end
         default: begin
            full  = ua * ub;
            r.res = W'(full % m);
            r.hi  = W'(full / m);
            r.c   = (full / m) != 0;
         end
      endcase
      r.z = (r.res == 0) && (r.hi == 0);
      return r;
   endfunction

   // Starts and ends on a falling edge; latency counts the accept edge as cycle 1
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                         output res_t got, output int lat, output logic rdy_before,
                         output logic single, output logic rdy_after, output time t_acc);
      rdy_before = in_ready;
      a         = ta;
      b         = tb;
      op        = top;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1 in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 4 * W) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
      got = observed();
      @(negedge clk);
      single    = !out_valid;
      rdy_after = in_ready;
   endtask

   task automatic test_reset;
      res_t o;
      #2;
      o = observed();
      n_vectors++;
      if ({in_ready, out_valid, o} !== '0) begin
         n_miscompares++;
         $display("[TB] FAIL reset_outputs: in_ready=%b out_valid=%b %s, required all zero",
                  in_ready, out_valid, show(o));
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_miscompares++;
         $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, required 1 0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_directed;
      dir_t tbl[8];
      res_t got;
      int   lat;
      int   exp_lat;
      logic rb, sg, ra;
      time  t;
      tbl[0] = '{8'h7F, 8'h01, 3'd0, res_t'{8'h80, 8'h00, 1'b0, 1'b1, 1'b0}};
      tbl[1] = '{8'h03, 8'h05, 3'd1, res_t'{8'hFE, 8'h00, 1'b1, 1'b0, 1'b0}};
      tbl[2] = '{8'h80, 8'h01, 3'd1, res_t'{8'h7F, 8'h00, 1'b0, 1'b1, 1'b0}};
      tbl[3] = '{8'hFF, 8'hFF, 3'd7, res_t'{8'h01, 8'hFE, 1'b1, 1'b0, 1'b0}};
      tbl[4] = '{8'h00, 8'h37, 3'd7, res_t'{8'h00, 8'h00, 1'b0, 1'b0, 1'b1}};
      tbl[5] = '{8'h81, 8'h01, 3'd5, res_t'{8'h02, 8'h00, 1'b1, 1'b0, 1'b0}};
      tbl[6] = '{8'h81, 8'h00, 3'd6, res_t'{8'h81, 8'h00, 1'b0, 1'b0, 1'b0}};
      tbl[7] = '{8'h5A, 8'h5A, 3'd4, res_t'{8'h00, 8'h00, 1'b0, 1'b0, 1'b1}};
      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].op, got, lat, rb, sg, ra, t);
         exp_lat = (tbl[i].op == 3'd7) ? W + 1 : 1;
         n_vectors++;
         if (got !== tbl[i].exp) begin
            n_miscompares++;
            $display("[TB] FAIL directed_%0d_value: got %s, required %s", i, show(got), show(tbl[i].exp));
         end
         n_vectors++;
         if (lat !== exp_lat) begin
            n_miscompares++;
            $display("[TB] FAIL directed_%0d_latency: got %0d, required %0d", i, lat, exp_lat);
         end
         n_vectors++;
         if ({rb, sg, ra} !== 3'b111) begin
            n_miscompares++;
            $display("[TB] FAIL directed_%0d_handshake: ready_before=%b single_pulse=%b ready_after=%b, required 1 1 1",
                     i, rb, sg, ra);
         end
      end
   endtask

   task automatic test_backpressure;
      res_t exp = res_t'{8'h30, 8'h00, 1'b0, 1'b0, 1'b0};
      res_t snap;
      int   n;
      int   bad;
      a         = 8'hF0;
      b         = 8'h3C;
      op        = 3'd2;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 4 * W) begin
         @(negedge clk);
         n++;
      end
      snap = observed();
      n_vectors++;
      if (!out_valid || snap !== exp) begin
         n_miscompares++;
         $display("[TB] FAIL bp_result: out_valid=%b %s, required out_valid=1 %s",
                  out_valid, show(snap), show(exp));
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!out_valid || in_ready || observed() !== exp) bad++;
         if (i == 1) begin
            a        = 8'h55;
            b        = 8'hAA;
            op       = 3'd0;
            in_valid = 1'b1;
         end
         if (i == 2) in_valid = 1'b0;
      end
      n_vectors++;
      if (bad !== 0) begin
         n_miscompares++;
         $display("[TB] FAIL bp_hold: %0d unstable cycles, required 0 (now %s)", bad, show(observed()));
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_miscompares++;
         $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_mul;
      res_t got;
      int   lat;
      int   bad;
      logic rb, sg, ra;
      time  t;
      a         = 8'hFF;
      b         = 8'hFF;
      op        = 3'd7;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      got = observed();
      n_vectors++;
      if ({in_ready, out_valid, got} !== '0) begin
         n_miscompares++;
         $display("[TB] FAIL midmul_reset: in_ready=%b out_valid=%b %s, required all zero",
                  in_ready, out_valid, show(got));
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) bad++;
      end
      n_vectors++;
      if (bad !== 0) begin
         n_miscompares++;
         $display("[TB] FAIL midmul_stale: %0d cycles with stale output or not ready, required 0", bad);
      end
      run_op(8'h01, 8'h01, 3'd0, got, lat, rb, sg, ra, t);
      n_vectors++;
      if (got !== res_t'{8'h02, 8'h00, 1'b0, 1'b0, 1'b0} || lat !== 1 || !sg) begin
         n_miscompares++;
         $display("[TB] FAIL midmul_fresh_add: got %s latency=%0d single=%b, required res=02 rest 0 latency=1 single=1",
                  show(got), lat, sg);
      end
   endtask

   task automatic test_random;
      res_t         got, exp;
      int           lat;
      logic         rb, sg, ra;
      time          t;
      logic [W-1:0] ra_op, rb_op;
      logic [2:0]   rop;
      for (int i = 0; i < 60; i++) begin
         ra_op = W'($urandom);
         rb_op = W'($urandom);
         rop   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) ra_op = '0;
         if ($urandom_range(0, 7) == 0) rb_op = ra_op;
         exp = model(ra_op, rb_op, rop);
         run_op(ra_op, rb_op, rop, got, lat, rb, sg, ra, t);
         n_vectors++;
         if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got %s, required %s",
                     i, rop, ra_op, rb_op, show(got), show(exp));
         end
         n_vectors++;
         if (lat !== ((rop == 3'd7) ? W + 1 : 1) || !sg) begin
            n_miscompares++;
            $display("[TB] FAIL random_%0d_timing op=%0d: latency=%0d single=%b, required %0d 1",
                     i, rop, lat, sg, (rop == 3'd7) ? W + 1 : 1);
         end
      end
   endtask

   task automatic test_back_to_back;
      res_t         got, exp;
      int           lat;
      logic         rb, sg, ra;
      time          t, t_prev;
      logic [W-1:0] ra_op, rb_op;
      logic [2:0]   rop;
      t_prev = 0;
      for (int i = 0; i < 12; i++) begin
         ra_op = W'($urandom);
         rb_op = W'($urandom);
         rop   = 3'($urandom_range(0, 6));
         exp   = model(ra_op, rb_op, rop);
         run_op(ra_op, rb_op, rop, got, lat, rb, sg, ra, t);
         n_vectors++;
         if (got !== exp || !rb) begin
            n_miscompares++;
            $display("[TB] FAIL b2b_%0d op=%0d a=%h b=%h: got %s ready=%b, required %s ready=1",
                     i, rop, ra_op, rb_op, show(got), rb, show(exp));
         end
         if (i > 0) begin
            n_vectors++;
            if (t - t_prev !== 20) begin
               n_miscompares++;
               $display("[TB] FAIL b2b_%0d_spacing: accepts %0t apart, required 20", i, t - t_prev);
            end
         end
         t_prev = t;
      end
   endtask

   initial begin
      n_vectors     = 0;
      n_miscompares = 0;
      rst_n         = 1'b0;
      in_valid      = 1'b0;
      out_ready     = 1'b0;
      a             = '0;
      b             = '0;
      op            = '0;
      test_reset;
      test_directed;
      test_backpressure;
      test_reset_mid_mul;
      test_random;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
